// File: rtl/req_dsc_rd_dma_if.sv
// req_dsc_rd_dma_if: command, AXI read-channel and descriptor-stream signals of the descriptor read DMA.
// The master modport is the DMA side; the slave modport is the surrounding system.
interface req_dsc_rd_dma_if;
   logic [31:0] s_dsc_cmd_baseaddr;
   logic [15:0] s_dsc_cmd_num;
   logic        s_dsc_cmd_valid;
   logic        s_dsc_cmd_ready;
   logic [31:0] m_axi_araddr;
   logic [1:0]  m_axi_arburst;
   logic [7:0]  m_axi_arlen;
   logic [2:0]  m_axi_arsize;
   logic        m_axi_arvalid;
   logic        m_axi_arready;
   logic [63:0] m_axi_rdata;
   logic [1:0]  m_axi_rresp;
   logic        m_axi_rlast;
   logic        m_axi_rvalid;
   logic        m_axi_rready;
   logic [63:0] m_dsc_data;
   logic        m_dsc_last;
   logic        m_dsc_valid;
   logic        m_dsc_ready;
   logic        dma_done;
   logic [1:0]  dma_err;
   modport master (
      input  s_dsc_cmd_baseaddr, s_dsc_cmd_num, s_dsc_cmd_valid, m_axi_arready,
             m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, m_dsc_ready,
      output s_dsc_cmd_ready, m_axi_araddr, m_axi_arburst, m_axi_arlen, m_axi_arsize,
             m_axi_arvalid, m_axi_rready, m_dsc_data, m_dsc_last, m_dsc_valid, dma_done, dma_err
   );
   modport slave (
      output s_dsc_cmd_baseaddr, s_dsc_cmd_num, s_dsc_cmd_valid, m_axi_arready,
             m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_rvalid, m_dsc_ready,
      input  s_dsc_cmd_ready, m_axi_araddr, m_axi_arburst, m_axi_arlen, m_axi_arsize,
             m_axi_arvalid, m_axi_rready, m_dsc_data, m_dsc_last, m_dsc_valid, dma_done, dma_err
   );
endinterface

// File: rtl/req_dsc_rd_dma.sv
// req_dsc_rd_dma: fetches 64-bit request descriptors over AXI read, one INCR burst at a time,
// bursts capped at max_burst_len beats and never crossing a 4KB boundary.
module req_dsc_rd_dma #(
   parameter int max_burst_len = 16
) (
   input logic        clk,
   input logic        rst_n,
   req_dsc_rd_dma_if.master bus
);
   typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_addr, w_naddr;
   logic [15:0] r_rem, w_nrem, w_b4k, w_bcap, w_blen;
   logic [7:0]  r_arlen, r_cnt;
   logic [8:0]  w_cur;
   logic [1:0]  r_err;
   logic        w_ld, w_beat, w_fin, w_eob, w_unused;
   assign w_ld   = r_state == IDLE && bus.s_dsc_cmd_valid;
   assign w_beat = r_state == R && bus.m_axi_rvalid && bus.m_dsc_ready;
   assign w_fin  = r_cnt == r_arlen;
   assign w_eob  = w_beat && w_fin;
   assign w_cur  = {1'b0, r_arlen} + 9'd1;
   // Next burst is sized from the address/remaining count it will start with, so araddr/arlen
   // are ready the cycle arvalid rises.
   assign w_naddr  = w_ld ? {bus.s_dsc_cmd_baseaddr[31:3], 3'b000} : r_addr + {20'd0, w_cur, 3'b000};
   assign w_nrem   = w_ld ? bus.s_dsc_cmd_num : r_rem - {7'd0, w_cur};
   assign w_b4k    = 16'd512 - {7'd0, w_naddr[11:3]};
   assign w_bcap   = w_nrem < 16'(max_burst_len) ? w_nrem : 16'(max_burst_len);
   assign w_blen   = w_bcap < w_b4k ? w_bcap : w_b4k;
   assign w_unused = &{1'b0, bus.s_dsc_cmd_baseaddr[2:0]};
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = !bus.s_dsc_cmd_valid ? IDLE : bus.s_dsc_cmd_num == 16'd0 ? DONE : AR;
         AR:      w_next = bus.m_axi_arready ? R : AR;
         R:       w_next = !w_eob ? R : w_nrem == 16'd0 ? DONE : AR;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= 8'd0;
         r_err   <= 2'b00;
      end else begin
         r_state <= w_next;
         r_cnt   <= r_state != R ? 8'd0 : w_beat ? r_cnt + 8'd1 : r_cnt;
         r_err   <= w_ld ? 2'b00 : r_err | {w_beat && (bus.m_axi_rlast != w_fin), w_beat && bus.m_axi_rresp != 2'b00};
      end
   end
   always_ff @(posedge clk) begin
      if (w_ld || w_eob) begin
         r_addr  <= w_naddr;
         r_rem   <= w_nrem;
         r_arlen <= 8'(w_blen - 16'd1);
      end
   end
   assign bus.s_dsc_cmd_ready = r_state == IDLE;
   assign bus.m_axi_araddr    = r_addr;
   assign bus.m_axi_arlen     = r_arlen;
   assign bus.m_axi_arburst   = 2'b01;
   assign bus.m_axi_arsize    = 3'b011;
   assign bus.m_axi_arvalid   = r_state == AR;
   assign bus.m_axi_rready    = r_state == R && bus.m_dsc_ready;
   assign bus.m_dsc_valid     = r_state == R && bus.m_axi_rvalid;
   assign bus.m_dsc_data      = bus.m_axi_rdata;
   assign bus.m_dsc_last      = r_state == R && w_fin && r_rem == {7'd0, w_cur};
   assign bus.dma_done        = r_state == DONE;
   assign bus.dma_err         = r_err;
endmodule
